// File: rtl/alu_result_monitor.sv
// rtl/alu_result_monitor.sv - two-stage ALU result checker with saturating counters and first-failure capture
// Define ALU_MON_HALT_ON_FAIL_EN to freeze the monitor in HALT after the first failure.
module alu_result_monitor #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             valid,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [2:0]       operation,
   input  logic [31:0]      result,
   input  logic             zero,
   output logic [CNT_W-1:0] check_count,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [CNT_W-1:0] illegal_count,
   output logic             err,
   output logic [2:0]       fail_op,
   output logic [31:0]      fail_a,
   output logic [31:0]      fail_b,
   output logic [31:0]      fail_result,
   output logic [31:0]      fail_expected,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

   state_t           state_q, state_d;
   logic             s1_valid_q, s1_valid_d;
   logic [31:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_result_q, s1_result_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             s1_zero_q, s1_zero_d;
   logic [CNT_W-1:0] check_q, check_d, pass_q, pass_d, fail_q, fail_d, illegal_q, illegal_d;
   logic             err_q, err_d;
   logic [2:0]       fail_op_q, fail_op_d;
   logic [31:0]      fail_a_q, fail_a_d, fail_b_q, fail_b_d;
   logic [31:0]      fail_result_q, fail_result_d, fail_expected_q, fail_expected_d;

   logic [31:0] expected;
   logic        legal, mismatch, fail_now, halt_now, accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   always_comb begin
      legal    = 1'b1;
      expected = 32'd0;
      case (s1_op_q)
         3'b000:  expected = s1_a_q & s1_b_q;
         3'b001:  expected = s1_a_q | s1_b_q;
         3'b010:  expected = s1_a_q + s1_b_q;
         3'b110:  expected = s1_a_q - s1_b_q;
         3'b111:  expected = {31'b0, $signed(s1_a_q) < $signed(s1_b_q)};
         default: legal = 1'b0;
      endcase
      mismatch = (s1_result_q != expected) || (s1_zero_q != (expected == 32'd0));
      fail_now = s1_valid_q && legal && mismatch;
   end

`ifdef ALU_MON_HALT_ON_FAIL_EN
   assign halt_now = fail_now;
`else
   assign halt_now = 1'b0;
`endif

   // A sample arriving on the edge that halts the monitor is dropped with it.
   assign accept = valid && (state_q != HALT) && !halt_now;

   always_comb begin
      state_d         = state_q;
      s1_valid_d      = 1'b0;
      s1_a_d          = s1_a_q;
      s1_b_d          = s1_b_q;
      s1_op_d         = s1_op_q;
      s1_result_d     = s1_result_q;
      s1_zero_d       = s1_zero_q;
      check_d         = check_q;
      pass_d          = pass_q;
      fail_d          = fail_q;
      illegal_d       = illegal_q;
      err_d           = err_q;
      fail_op_d       = fail_op_q;
      fail_a_d        = fail_a_q;
      fail_b_d        = fail_b_q;
      fail_result_d   = fail_result_q;
      fail_expected_d = fail_expected_q;
      if (clear) begin
         state_d         = IDLE;
         s1_a_d          = 32'd0;
         s1_b_d          = 32'd0;
         s1_op_d         = 3'd0;
         s1_result_d     = 32'd0;
         s1_zero_d       = 1'b0;
         check_d         = '0;
         pass_d          = '0;
         fail_d          = '0;
         illegal_d       = '0;
         err_d           = 1'b0;
         fail_op_d       = 3'd0;
         fail_a_d        = 32'd0;
         fail_b_d        = 32'd0;
         fail_result_d   = 32'd0;
         fail_expected_d = 32'd0;
      end else begin
         if (accept) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = a;
            s1_b_d      = b;
            s1_op_d     = operation;
            s1_result_d = result;
            s1_zero_d   = zero;
            if (state_q == IDLE) state_d = RUN;
         end
         if (s1_valid_q) begin
            check_d = sat_inc(check_q);
            if (!legal)        illegal_d = sat_inc(illegal_q);
            else if (mismatch) fail_d    = sat_inc(fail_q);
            else               pass_d    = sat_inc(pass_q);
         end
         if (fail_now && !err_q) begin
            err_d           = 1'b1;
            fail_op_d       = s1_op_q;
            fail_a_d        = s1_a_q;
            fail_b_d        = s1_b_q;
            fail_result_d   = s1_result_q;
            fail_expected_d = expected;
         end
         if (halt_now) state_d = HALT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         s1_valid_q      <= 1'b0;
         s1_a_q          <= 32'd0;
         s1_b_q          <= 32'd0;
         s1_op_q         <= 3'd0;
         s1_result_q     <= 32'd0;
         s1_zero_q       <= 1'b0;
         check_q         <= '0;
         pass_q          <= '0;
         fail_q          <= '0;
         illegal_q       <= '0;
         err_q           <= 1'b0;
         fail_op_q       <= 3'd0;
         fail_a_q        <= 32'd0;
         fail_b_q        <= 32'd0;
         fail_result_q   <= 32'd0;
         fail_expected_q <= 32'd0;
      end else begin
         state_q         <= state_d;
         s1_valid_q      <= s1_valid_d;
         s1_a_q          <= s1_a_d;
         s1_b_q          <= s1_b_d;
         s1_op_q         <= s1_op_d;
         s1_result_q     <= s1_result_d;
         s1_zero_q       <= s1_zero_d;
         check_q         <= check_d;
         pass_q          <= pass_d;
         fail_q          <= fail_d;
         illegal_q       <= illegal_d;
         err_q           <= err_d;
         fail_op_q       <= fail_op_d;
         fail_a_q        <= fail_a_d;
         fail_b_q        <= fail_b_d;
         fail_result_q   <= fail_result_d;
         fail_expected_q <= fail_expected_d;
      end
   end

   assign check_count   = check_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign illegal_count = illegal_q;
   assign err           = err_q;
   assign fail_op       = fail_op_q;
   assign fail_a        = fail_a_q;
   assign fail_b        = fail_b_q;
   assign fail_result   = fail_result_q;
   assign fail_expected = fail_expected_q;
   assign state         = state_q;

endmodule

// File: tb/tb_alu_result_monitor.sv
// tb/tb_alu_result_monitor.sv - randomized self-checking bench for alu_result_monitor against a transaction-level model
module tb_alu_result_monitor;
   logic clk = 1'b0, reset = 1'b1, clear = 1'b0, valid = 1'b0, zero = 1'b0;
   logic [31:0] a = '0, b = '0, result = '0;
   logic [2:0]  operation = '0;

   logic [15:0] check_count, pass_count, fail_count, illegal_count;
   logic        err;
   logic [2:0]  fail_op;
   logic [31:0] fail_a, fail_b, fail_result, fail_expected;
   logic [1:0]  state;

   logic [3:0]  s_check, s_pass, s_fail, s_ill;
   logic        s_err;
   logic [2:0]  s_fop;
   logic [31:0] s_fa, s_fb, s_fres, s_fexp;
   logic [1:0]  s_state;

   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   alu_result_monitor #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .valid(valid), .a(a), .b(b),
      .operation(operation), .result(result), .zero(zero),
      .check_count(check_count), .pass_count(pass_count), .fail_count(fail_count),
      .illegal_count(illegal_count), .err(err), .fail_op(fail_op), .fail_a(fail_a),
      .fail_b(fail_b), .fail_result(fail_result), .fail_expected(fail_expected), .state(state));

   alu_result_monitor #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .clear(clear), .valid(valid), .a(a), .b(b),
      .operation(operation), .result(result), .zero(zero),
      .check_count(s_check), .pass_count(s_pass), .fail_count(s_fail),
      .illegal_count(s_ill), .err(s_err), .fail_op(s_fop), .fail_a(s_fa),
      .fail_b(s_fb), .fail_result(s_fres), .fail_expected(s_fexp), .state(s_state));

   logic [197:0] act_vec;
   assign act_vec = {check_count, pass_count, fail_count, illegal_count, err, fail_op,
                     fail_a, fail_b, fail_result, fail_expected, state};

   // Transaction-level model: at most one sample waits between capture and scoring.
   int          m_check, m_pass, m_fail, m_ill;
   logic        m_err;
   logic [2:0]  m_fop;
   logic [31:0] m_fa, m_fb, m_fres, m_fexp;
   logic [1:0]  m_state;
   bit          p_v;
   logic [2:0]  p_op;
   logic [31:0] p_a, p_b, p_r;
   logic        p_z;

   function automatic void golden(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] e, output bit lg);
      lg = 1;
      e  = 0;
      case (op)
         3'd0: e = x & y;
         3'd1: e = x | y;
         3'd2: e = x + y;
         3'd6: e = x - y;
         3'd7: e = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: lg = 0;
      endcase
   endfunction

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   function automatic logic [197:0] exp_vec();
      return {sat16(m_check), sat16(m_pass), sat16(m_fail), sat16(m_ill), m_err, m_fop,
              m_fa, m_fb, m_fres, m_fexp, m_state};
   endfunction

   task automatic model_clear();
      m_check = 0; m_pass = 0; m_fail = 0; m_ill = 0; m_err = 0; m_fop = 0;
      m_fa = 0; m_fb = 0; m_fres = 0; m_fexp = 0; m_state = 2'b00; p_v = 0;
   endtask

   task automatic cycle(input bit v, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic z, input bit clr);
      logic [31:0] e;
      bit lg;
      valid = v; operation = op; a = x; b = y; result = r; zero = z; clear = clr;
      @(posedge clk);
      if (clr) model_clear();
      else begin
         if (p_v) begin
            golden(p_op, p_a, p_b, e, lg);
            m_check++;
            if (!lg) m_ill++;
            else if (p_r === e && p_z === (e == 0)) m_pass++;
            else begin
               m_fail++;
               if (!m_err) begin
                  m_err = 1; m_fop = p_op; m_fa = p_a; m_fb = p_b; m_fres = p_r; m_fexp = e;
               end
`ifdef ALU_MON_HALT_ON_FAIL_EN
               m_state = 2'b10;
`endif
            end
         end
         p_v = 0;
         if (v && m_state != 2'b10) begin
            p_v = 1; p_op = op; p_a = x; p_b = y; p_r = r; p_z = z;
            if (m_state == 2'b00) m_state = 2'b01;
         end
      end
      @(negedge clk);
      valid = 0; clear = 0;
   endtask

   task automatic idle();
      cycle(0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
   endtask

   task automatic legal_ok(output logic [2:0] op, output logic [31:0] x, output logic [31:0] y,
                           output logic [31:0] r, output logic z);
      bit lg;
      case ($urandom_range(0, 4))
         0: op = 3'd0;
         1: op = 3'd1;
         2: op = 3'd2;
         3: op = 3'd6;
         default: op = 3'd7;
      endcase
      x = $urandom; y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      golden(op, x, y, r, lg);
      z = (r == 0);
   endtask

   task automatic test_reset();
      model_clear();
      repeat (2) @(negedge clk);
      reset = 0;
      n_checks++;
      if (act_vec !== 198'd0) begin
         n_fail++; $display("FAIL reset_state: got %h want 0", act_vec);
      end
      cycle(1, 3'd2, 32'd1, 32'd2, 32'd3, 1'b0, 0);
      cycle(1, 3'd0, 32'd1, 32'd2, 32'd7, 1'b0, 0);
      valid = 1;
      #2 reset = 1;
      #1;
      model_clear();
      n_checks++;
      if (act_vec !== 198'd0) begin
         n_fail++; $display("FAIL async_reset: got %h want 0", act_vec);
      end
      @(negedge clk);
      reset = 0; valid = 0;
      idle();
      n_checks++;
      if (check_count !== 16'd0 || state !== 2'b00) begin
         n_fail++; $display("FAIL reset_discard: check=%0d state=%b want 0 00", check_count, state);
      end
   endtask

   task automatic test_latency();
      cycle(1, 3'd0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1);
      cycle(1, 3'd0, 32'hF0, 32'h3C, 32'h30, 1'b0, 0);
      n_checks++;
      if (check_count !== 16'd0 || state !== 2'b01) begin
         n_fail++; $display("FAIL latency_edge_k: check=%0d state=%b want 0 01", check_count, state);
      end
      idle();
      n_checks++;
      if (check_count !== 16'd1 || pass_count !== 16'd1) begin
         n_fail++; $display("FAIL latency_edge_k1: check=%0d pass=%0d want 1 1", check_count, pass_count);
      end
   endtask

   task automatic test_legal_ops();
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      cycle(1, 3'b000, 32'h0000FFFF, 32'h1, 32'h00000001, 1'b0, 0);
      cycle(1, 3'b001, 32'h0000FFFF, 32'h1, 32'h0000FFFF, 1'b0, 0);
      cycle(1, 3'b010, 32'h0000FFFF, 32'h1, 32'h00010000, 1'b0, 0);
      cycle(1, 3'b110, 32'h0000FFFF, 32'h1, 32'h0000FFFE, 1'b0, 0);
      cycle(1, 3'b111, 32'h0000FFFF, 32'h1, 32'h00000000, 1'b1, 0);
      idle();
      n_checks++;
      if (check_count !== 16'd5 || pass_count !== 16'd5 || fail_count !== 16'd0 || state !== 2'b01) begin
         n_fail++;
         $display("FAIL five_ops: check=%0d pass=%0d fail=%0d state=%b want 5 5 0 01",
                  check_count, pass_count, fail_count, state);
      end
   endtask

   task automatic test_signed_slt();
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      cycle(1, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 0);
      idle();
      n_checks++;
      if (fail_count !== 16'd1 || err !== 1'b1 || fail_expected !== 32'h1 || fail_op !== 3'b111) begin
         n_fail++;
         $display("FAIL signed_slt: fail=%0d err=%b exp=%h op=%b want 1 1 00000001 111",
                  fail_count, err, fail_expected, fail_op);
      end
   endtask

   task automatic test_zero_flag();
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      cycle(1, 3'b110, 32'h5, 32'h5, 32'h0, 1'b0, 0);
      idle();
      n_checks++;
      if (fail_count !== 16'd1 || pass_count !== 16'd0) begin
         n_fail++; $display("FAIL zero_flag: fail=%0d pass=%0d want 1 0", fail_count, pass_count);
      end
      cycle(1, 3'b000, 32'h3, 32'h3, 32'h7, 1'b0, 0);
      idle();
      n_checks++;
      if (err !== 1'b1 || fail_op !== 3'b110 || fail_a !== 32'h5 || fail_b !== 32'h5 ||
          fail_result !== 32'h0 || fail_expected !== 32'h0) begin
         n_fail++;
         $display("FAIL first_capture: err=%b op=%b a=%h b=%h res=%h exp=%h want 1 110 5 5 0 0",
                  err, fail_op, fail_a, fail_b, fail_result, fail_expected);
      end
   endtask

   task automatic test_illegal();
      logic [2:0] op;
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         op = 3'b100;
         cycle(1, op, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
      end
      idle();
      n_checks++;
      if (illegal_count !== 16'd10 || pass_count !== 16'd0 || fail_count !== 16'd0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_op: ill=%0d pass=%0d fail=%0d err=%b want 10 0 0 0",
                  illegal_count, pass_count, fail_count, err);
      end
   endtask

   task automatic test_saturation();
      logic [2:0] op;
      logic [31:0] x, y, r;
      logic z;
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         legal_ok(op, x, y, r, z);
         cycle(1, op, x, y, r, z, 0);
      end
      idle();
      n_checks++;
      if (s_pass !== 4'hF || s_check !== 4'hF || pass_count !== 16'd20) begin
         n_fail++;
         $display("FAIL saturation: sat_pass=%h sat_check=%h pass=%0d want F F 20", s_pass, s_check, pass_count);
      end
   endtask

   task automatic test_clear_with_valid();
      cycle(1, 3'b010, 32'h1, 32'h1, 32'h5, 1'b0, 0);
      cycle(1, 3'b000, 32'h1, 32'h1, 32'h1, 1'b0, 0);
      cycle(1, 3'b001, 32'h2, 32'h1, 32'h3, 1'b0, 1);
      n_checks++;
      if (act_vec !== 198'd0) begin
         n_fail++; $display("FAIL clear_now: got %h want 0", act_vec);
      end
      idle();
      idle();
      n_checks++;
      if (check_count !== 16'd0 || state !== 2'b00 || s_check !== 4'd0) begin
         n_fail++; $display("FAIL clear_drop: check=%0d state=%b want 0 00", check_count, state);
      end
   endtask

   task automatic test_halt();
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      cycle(1, 3'b010, 32'h1, 32'h1, 32'h0, 1'b1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 0);
      idle();
      idle();
      n_checks++;
`ifdef ALU_MON_HALT_ON_FAIL_EN
      if (check_count !== 16'd1 || pass_count !== 16'd0 || state !== 2'b10) begin
         n_fail++; $display("FAIL halt: check=%0d pass=%0d state=%b want 1 0 10", check_count, pass_count, state);
      end
`else
      if (check_count !== 16'd4 || pass_count !== 16'd3 || state !== 2'b01) begin
         n_fail++; $display("FAIL no_halt: check=%0d pass=%0d state=%b want 4 3 01", check_count, pass_count, state);
      end
`endif
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      n_checks++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL halt_clear: state=%b want 00", state);
      end
   endtask

   task automatic test_random();
      logic [2:0] op;
      logic [31:0] x, y, r;
      logic z;
      cycle(0, 3'd0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(3, 5));
         legal_ok(op, x, y, r, z);
         if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(3, 5));
         if ($urandom_range(0, 5) == 0) r = r ^ (32'd1 << $urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) z = ~z;
         cycle(1'($urandom_range(0, 3) != 0), op, x, y, r, z, $urandom_range(0, 59) == 0);
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL random[%0d]: got %h want %h", i, act_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_legal_ops();
      test_signed_slt();
      test_zero_flag();
      test_illegal();
      test_saturation();
      test_clear_with_valid();
      test_halt();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_result_monitor.md
# alu_result_monitor

Self-checking receiver for the ALU lab: samples every ALU transaction (operands, operation code, result, zero flag) and compares it against an internal golden model. It maintains pass, fail and illegal-opcode counters and captures the first failing transaction for readout. It sits beside the ALU in the lab3 bench and on-board harness, consuming the same `a`, `b` and `operation` that drive the ALU, plus the ALU's `result` and `zero`.

## Interface

- `CNT_W`, 16: width of every event counter.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `clear`  input  1  synchronous clear of counters, capture registers and state.
- `valid`  input  1  transaction present this cycle.
- `a`  input  32  ALU operand A.
- `b`  input  32  ALU operand B.
- `operation`  input  3  ALU op code.
- `result`  input  32  ALU result under check.
- `zero`  input  1  ALU zero flag under check.
- `check_count`  output  CNT_W  accepted transactions.
- `pass_count`  output  CNT_W  legal-op transactions that matched.
- `fail_count`  output  CNT_W  legal-op transactions that mismatched.
- `illegal_count`  output  CNT_W  transactions with an undefined op code.
- `err`  output  1  sticky, set on the first failure.
- `fail_op`  output  3  op code of the first failure.
- `fail_a`, `fail_b`  output  32 each  operands of the first failure.
- `fail_result`  output  32  DUT result of the first failure.
- `fail_expected`  output  32  golden result of the first failure.
- `state`  output  2  FSM state: 00 IDLE, 01 RUN, 10 HALT.

## Operation

- **Golden model:**
  - 000: `a & b`.
  - 001: `a | b`.
  - 010: `a + b` mod 2^32.
  - 110: `a - b` mod 2^32.
  - 111: `{31'b0, $signed(a) < $signed(b)}`.
- **Illegal codes:** 011, 100 and 101.
- **Mismatch:** `result != expected`, or `zero != (expected == 0)`.
- **Stage 1:** on an edge with `valid=1`, register `a`, `b`, `operation`, `result`, `zero` and a stage-valid bit.
- **Stage 2:** on the next edge, compute the expected value from the stage registers and update counters:
  - `check_count` +1 for every stage-valid sample.
  - Illegal op: `illegal_count` +1; pass and fail counters untouched.
  - Legal match: `pass_count` +1.
  - Legal mismatch: `fail_count` +1.
  - Legal mismatch while `err=0`: load all `fail_*` registers and set `err`.
- **Saturation:** every counter sticks at all-ones and never wraps.
- **FSM:**
  - IDLE → RUN on the first accepted `valid`.
  - RUN stays RUN.
  - RUN → HALT on the first failure, only when halting is configured (see Configuration).
  - Any state → IDLE on `clear`.
- **Reset:** all outputs 0 and `state`=IDLE. Reset mid-pipeline discards the in-flight sample.
- **`clear`:**
  - Same effect as reset, applied at the clock edge.
  - Priority over `valid` in the same cycle: that sample is dropped.
  - A sample already in stage 1 is also discarded.
- **Back-to-back `valid`:** accepted every cycle, no bubbles. Throughput is one transaction per clock.

## Timing

- Transaction presented with `valid=1` before edge k is captured at edge k.
- Counters, `err` and `fail_*` update at edge k+1.
- Two edges from input to visible count.
- `err` and `fail_*` never change after the first failure until `reset` or `clear`.
- A failure and the next sample in the same cycle: the next sample is still captured in stage 1.
- The HALT transition happens at the same edge as the failure count.

## Configuration

- `ALU_MON_HALT_ON_FAIL_EN` defined:
  - The first failure moves the FSM to HALT.
  - In HALT, `valid` is ignored and no counter changes.
  - A sample already in stage 1 when the failure is counted is discarded.
  - Only `clear` or `reset` exits HALT.
- Not defined:
  - HALT is unreachable.
  - The monitor keeps counting after failures; `err` and `fail_*` remain first-failure-only.

## Test plan

- **Reset / IDLE:** assert `reset` mid-stream → all counters 0, `err`=0, `state`=00 immediately (asynchronous).
- **Five legal ops, all matching:** `a`=0000FFFF, `b`=00000001, one op per cycle:
  - 000 → `result` 00000001.
  - 001 → `result` 0000FFFF.
  - 010 → `result` 00010000.
  - 110 → `result` 0000FFFE.
  - 111 → `result` 00000000, `zero`=1.
  - Required: `check_count`=5, `pass_count`=5, `fail_count`=0, `state`=RUN.
- **Signed slt:** `a`=FFFFFFFF, `b`=00000001, op 111, DUT `result`=0 → `fail_count`=1, `err`=1, `fail_expected`=00000001, `fail_op`=111.
- **Zero-flag and first-capture:** op 110 with `a`=`b`=00000005, `result`=0, `zero`=0 → mismatch counted; a later failing op leaves the `fail_*` fields unchanged.
- **Illegal op, saturation, clear:**
  - 10 samples with op 100 → `illegal_count`=10, `pass_count` and `fail_count` unchanged.
  - With `CNT_W`=4, 20 passes → `pass_count`=F.
  - `clear` together with `valid` → all zero, `state`=IDLE, that sample not counted.
- **Halt (macro defined):**
  - Failure followed by 3 valid matches → `check_count` frozen at the failure, `state`=HALT.
  - `clear` → `state`=IDLE.
  - Macro undefined: same stimulus gives `pass_count`=3 after the failure.
